// File: rtl/prefetch_req_arbiter.sv
// Shares the memory read-request port between demand reads and NUM_PF prefetchers,
// with per-source holding slots, starvation guard and outstanding-read tracking.
module prefetch_req_arbiter #(
  parameter int unsigned ADDR_BITS    = 64,
  parameter int unsigned NUM_PF       = 2,
  parameter int unsigned CNT_BITS     = 6,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned SRC_BITS     = $clog2(NUM_PF + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         dmdReqValid,
  input  logic [ADDR_BITS-1:0]         dmdReqAddr,
  output logic                         dmdReqReady,
  input  logic [NUM_PF-1:0]            pfReqValid,
  input  logic [NUM_PF*ADDR_BITS-1:0]  pfReqAddr,
  input  logic [NUM_PF-1:0]            pfFlush,
  output logic [NUM_PF-1:0]            pfSlotFree,
  output logic [NUM_PF-1:0]            pfDropped,
  output logic                         memReqValid,
  output logic [ADDR_BITS-1:0]         memReqAddr,
  output logic [SRC_BITS-1:0]          memReqSrc,
  input  logic                         memReqReady,
  input  logic                         memRspValid,
  input  logic [SRC_BITS-1:0]          memRspSrc,
  input  logic [CNT_BITS-1:0]          outstandingLimit,
  output logic [NUM_PF*CNT_BITS-1:0]   pfOutstandingCnt,
  output logic                         rspErr
);

  localparam int unsigned StBits  = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned PtrBits = (NUM_PF > 1) ? $clog2(NUM_PF) : 1;

  logic [NUM_PF-1:0]    slot_vld_q, slot_vld_d;
  logic [ADDR_BITS-1:0] slot_addr_q [NUM_PF];
  logic [ADDR_BITS-1:0] slot_addr_d [NUM_PF];
  logic [NUM_PF-1:0]    drop_q, drop_d;
  logic                 out_vld_q, out_vld_d;
  logic [ADDR_BITS-1:0] out_addr_q, out_addr_d;
  logic [SRC_BITS-1:0]  out_src_q, out_src_d;
  logic [CNT_BITS-1:0]  cnt_q [NUM_PF];
  logic [CNT_BITS-1:0]  cnt_d [NUM_PF];
  logic                 rsp_err_q, rsp_err_d;
  logic [StBits-1:0]    starve_q, starve_d;
  logic [PtrBits-1:0]   rr_q, rr_d;

  logic                 can_load, starved, any_occ, pf_any, dmd_grant, pf_grant;
  logic [NUM_PF-1:0]    eligible;
  logic [PtrBits-1:0]   pf_sel, cand;

  assign can_load = ~out_vld_q | memReqReady;
  assign starved  = (starve_q == StBits'(STARVE_LIMIT));
  assign any_occ  = |slot_vld_q;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_PF; i++) begin
      eligible[i] = slot_vld_q[i] & ~pfFlush[i] & (cnt_q[i] < outstandingLimit);
    end
  end

  // Round-robin search starting at the pointer.
  always_comb begin
    pf_any = 1'b0;
    pf_sel = '0;
    cand   = '0;
    for (int k = 0; k < NUM_PF; k++) begin
      cand = PtrBits'((int'(rr_q) + k) % NUM_PF);
      if (!pf_any && eligible[cand]) begin
        pf_any = 1'b1;
        pf_sel = cand;
      end
    end
  end

  assign dmd_grant = ~reset & can_load & dmdReqValid & ~(starved & pf_any);
  assign pf_grant  = ~reset & can_load & pf_any & ~dmd_grant;

  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_addr_d = slot_addr_q;
    drop_d     = '0;
    cnt_d      = cnt_q;
    rsp_err_d  = rsp_err_q;
    for (int i = 0; i < NUM_PF; i++) begin
      logic inc, dec;
      inc = pf_grant && (pf_sel == PtrBits'(i));
      dec = memRspValid && (memRspSrc == SRC_BITS'(i + 1));
      if (inc || pfFlush[i]) slot_vld_d[i] = 1'b0;
      if (pfReqValid[i]) begin
        if (!slot_vld_q[i] || pfFlush[i]) begin
          slot_vld_d[i]  = 1'b1;
          slot_addr_d[i] = pfReqAddr[i*ADDR_BITS +: ADDR_BITS];
        end else begin
          drop_d[i] = 1'b1;
        end
      end
      // Grant and completion in one cycle cancel out.
      if (dec && !inc) begin
        if (cnt_q[i] == '0) rsp_err_d = 1'b1;
        else                cnt_d[i]  = cnt_q[i] - CNT_BITS'(1);
      end else if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + CNT_BITS'(1);
      end
    end
  end

  always_comb begin
    out_vld_d  = out_vld_q;
    out_addr_d = out_addr_q;
    out_src_d  = out_src_q;
    if (can_load) begin
      out_vld_d = dmd_grant | pf_grant;
      if (dmd_grant) begin
        out_addr_d = dmdReqAddr;
        out_src_d  = '0;
      end else if (pf_grant) begin
        out_addr_d = slot_addr_q[pf_sel];
        out_src_d  = SRC_BITS'(pf_sel) + SRC_BITS'(1);
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    rr_d     = rr_q;
    if (pf_grant || !any_occ)      starve_d = '0;
    else if (dmd_grant && !starved) starve_d = starve_q + StBits'(1);
    if (pf_grant) rr_d = (pf_sel == PtrBits'(NUM_PF - 1)) ? '0 : pf_sel + PtrBits'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_vld_q <= '0;
      drop_q     <= '0;
      out_vld_q  <= 1'b0;
      out_addr_q <= '0;
      out_src_q  <= '0;
      rsp_err_q  <= 1'b0;
      starve_q   <= '0;
      rr_q       <= '0;
      for (int i = 0; i < NUM_PF; i++) begin
        slot_addr_q[i] <= '0;
        cnt_q[i]       <= '0;
      end
    end else begin
      slot_vld_q  <= slot_vld_d;
      slot_addr_q <= slot_addr_d;
      drop_q      <= drop_d;
      out_vld_q   <= out_vld_d;
      out_addr_q  <= out_addr_d;
      out_src_q   <= out_src_d;
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
      starve_q    <= starve_d;
      rr_q        <= rr_d;
    end
  end

  assign dmdReqReady = dmd_grant;
  assign pfSlotFree  = ~slot_vld_q;
  assign pfDropped   = drop_q;
  assign memReqValid = out_vld_q;
  assign memReqAddr  = out_addr_q;
  assign memReqSrc   = out_src_q;
  assign rspErr      = rsp_err_q;

  for (genvar g = 0; g < NUM_PF; g++) begin : g_cnt_out
    assign pfOutstandingCnt[g*CNT_BITS +: CNT_BITS] = cnt_q[g];
  end

endmodule

// File: tb/tb_prefetch_req_arbiter.sv
// Bench for prefetch_req_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a behavioural model of the arbitration rules.
module tb_prefetch_req_arbiter;
  localparam int AW = 64;
  localparam int NP = 2;
  localparam int CW = 6;
  localparam int SL = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             dmd_v, dmd_rdy;
  logic [AW-1:0]    dmd_a;
  logic [NP-1:0]    pf_v, pf_fl, slot_free, dropped;
  logic [NP*AW-1:0] pf_a;
  logic             mem_v, mem_rdy, rsp_v, rsp_err;
  logic [AW-1:0]    mem_a;
  logic [SW-1:0]    mem_src, rsp_src;
  logic [CW-1:0]    limit;
  logic [NP*CW-1:0] cnt_out;

  prefetch_req_arbiter dut (
    .clk(clk), .reset(reset),
    .dmdReqValid(dmd_v), .dmdReqAddr(dmd_a), .dmdReqReady(dmd_rdy),
    .pfReqValid(pf_v), .pfReqAddr(pf_a), .pfFlush(pf_fl),
    .pfSlotFree(slot_free), .pfDropped(dropped),
    .memReqValid(mem_v), .memReqAddr(mem_a), .memReqSrc(mem_src), .memReqReady(mem_rdy),
    .memRspValid(rsp_v), .memRspSrc(rsp_src),
    .outstandingLimit(limit), .pfOutstandingCnt(cnt_out), .rspErr(rsp_err)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state: what each slot holds, what is queued toward memory, counts.
  bit          m_occ [NP];
  logic [63:0] m_addr [NP];
  bit          m_drop [NP];
  bit          m_ov = 0;
  logic [63:0] m_oaddr = '0;
  int          m_osrc = 0;
  int          m_cnt [NP];
  bit          m_err = 0;
  int          m_starve = 0;
  int          m_rr = 0;
  bit          g_can, g_dmd, g_pf;
  int          g_sel;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_comb();
    int pick;
    g_can = !m_ov || mem_rdy;
    pick = -1;
    for (int k = 0; k < NP; k++) begin
      if (pick < 0 && m_occ[(m_rr + k) % NP] && !pf_fl[(m_rr + k) % NP] &&
          m_cnt[(m_rr + k) % NP] < int'(limit))
        pick = (m_rr + k) % NP;
    end
    g_dmd = !reset && g_can && dmd_v && !(m_starve == SL && pick >= 0);
    g_pf  = !reset && g_can && !g_dmd && pick >= 0;
    g_sel = pick;
  endtask

  task automatic model_seq();
    bit any_occ, inc, dec, was_occ;
    if (reset) begin
      m_ov = 0; m_oaddr = '0; m_osrc = 0; m_err = 0; m_starve = 0; m_rr = 0;
      for (int i = 0; i < NP; i++) begin
        m_occ[i] = 0; m_drop[i] = 0; m_cnt[i] = 0;
      end
      return;
    end
    any_occ = 0;
    for (int i = 0; i < NP; i++) any_occ |= m_occ[i];
    if (g_can) begin
      m_ov = g_dmd || g_pf;
      if (g_dmd) begin m_oaddr = dmd_a; m_osrc = 0; end
      else if (g_pf) begin m_oaddr = m_addr[g_sel]; m_osrc = g_sel + 1; end
    end
    if (g_pf || !any_occ) m_starve = 0;
    else if (g_dmd && m_starve < SL) m_starve++;
    if (g_pf) m_rr = (g_sel + 1) % NP;
    for (int i = 0; i < NP; i++) begin
      inc = g_pf && g_sel == i;
      dec = rsp_v && int'(rsp_src) == i + 1;
      if (dec && !inc) begin
        if (m_cnt[i] == 0) m_err = 1;
        else m_cnt[i]--;
      end else if (inc && !dec) m_cnt[i]++;
      was_occ = m_occ[i];
      m_drop[i] = 0;
      if (inc || pf_fl[i]) m_occ[i] = 0;
      if (pf_v[i]) begin
        if (!was_occ || pf_fl[i]) begin
          m_occ[i] = 1; m_addr[i] = pf_a[i*AW +: AW];
        end else m_drop[i] = 1;
      end
    end
  endtask

  task automatic compare_outputs();
    check_eq("mem_valid", 64'(mem_v), 64'(m_ov));
    if (m_ov) begin
      check_eq("mem_addr", mem_a, m_oaddr);
      check_eq("mem_src", 64'(mem_src), 64'(m_osrc));
    end
    for (int i = 0; i < NP; i++) begin
      check_eq("slot_free", 64'(slot_free[i]), 64'(!m_occ[i]));
      check_eq("dropped", 64'(dropped[i]), 64'(m_drop[i]));
      check_eq("out_cnt", 64'(cnt_out[i*CW +: CW]), 64'(m_cnt[i]));
    end
    check_eq("rsp_err", 64'(rsp_err), 64'(m_err));
  endtask

  // One clock: check the combinational ready, advance model at the edge, compare state.
  task automatic step();
    #1;
    model_comb();
    check_eq("dmd_ready", 64'(dmd_rdy), 64'(g_dmd));
    @(posedge clk);
    model_seq();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic quiet();
    dmd_v = 0; dmd_a = '0; pf_v = '0; pf_a = '0; pf_fl = '0;
    mem_rdy = 1; rsp_v = 0; rsp_src = '0; limit = 6'd8;
  endtask

  task automatic do_reset();
    quiet();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  int issues, drops;
  bit seen_new, seen_old;
  logic [SW-1:0] srcs [7];
  logic [AW-1:0] addr5;

  initial begin
    quiet();
    reset = 1;
    do_reset();
    check_eq("rst_valid", 64'(mem_v), 64'(0));
    check_eq("rst_addr", mem_a, 64'(0));
    check_eq("rst_src", 64'(mem_src), 64'(0));
    check_eq("rst_free", 64'(slot_free), 64'(2'b11));
    check_eq("rst_cnt", 64'(cnt_out), 64'(0));
    check_eq("rst_err", 64'(rsp_err), 64'(0));

    // Single prefetch round trip.
    pf_v = 2'b01; pf_a[AW-1:0] = 64'h1000;
    step();
    pf_v = '0;
    step();
    check_eq("t1_valid", 64'(mem_v), 64'(1));
    check_eq("t1_addr", mem_a, 64'h1000);
    check_eq("t1_src", 64'(mem_src), 64'(1));
    check_eq("t1_cnt_up", 64'(cnt_out[CW-1:0]), 64'(1));
    step();
    rsp_v = 1; rsp_src = 2'd1;
    step();
    rsp_v = 0;
    check_eq("t1_cnt_dn", 64'(cnt_out[CW-1:0]), 64'(0));
    check_eq("t1_no_err", 64'(rsp_err), 64'(0));

    // Completion with count already zero.
    rsp_v = 1; rsp_src = 2'd1;
    step();
    rsp_v = 0;
    check_eq("t6_cnt", 64'(cnt_out[CW-1:0]), 64'(0));
    check_eq("t6_err", 64'(rsp_err), 64'(1));
    for (int k = 0; k < 3; k++) step();
    check_eq("t6_sticky", 64'(rsp_err), 64'(1));

    // Starvation guard: four demand grants while slot 1 waits, then source 2.
    do_reset();
    dmd_v = 1; dmd_a = 64'h5000;
    pf_v = 2'b10; pf_a[2*AW-1:AW] = 64'h2000;
    step();
    pf_v = '0;
    srcs[0] = mem_src;
    for (int k = 1; k < 7; k++) begin
      step();
      srcs[k] = mem_src;
      if (k == 5) addr5 = mem_a;
    end
    dmd_v = 0;
    for (int k = 0; k < 7; k++) check_eq("t2_src", 64'(srcs[k]), (k == 5) ? 64'(2) : 64'(0));
    check_eq("t2_pf_addr", addr5, 64'h2000);

    // Outstanding cap of 2 with a pulse every cycle and no completions.
    do_reset();
    limit = 6'd2;
    issues = 0; drops = 0;
    for (int k = 0; k < 12; k++) begin
      pf_v = 2'b01; pf_a[AW-1:0] = 64'h3000 + 64'(k * 64);
      step();
      if (mem_v && mem_src == 2'd1) issues++;
      if (dropped[0]) drops++;
    end
    pf_v = '0;
    step();
    if (mem_v && mem_src == 2'd1) issues++;
    if (dropped[0]) drops++;
    check_eq("t3_issues", 64'(issues), 64'(2));
    check_eq("t3_drops", 64'(drops), 64'(9));
    check_eq("t3_occupied", 64'(slot_free[0]), 64'(0));
    check_eq("t3_cnt", 64'(cnt_out[CW-1:0]), 64'(2));

    // Backpressure: output held for 5 cycles, no demand accepted.
    do_reset();
    dmd_v = 1; dmd_a = 64'hABC0;
    step();
    mem_rdy = 0; dmd_a = 64'hDEAD;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("t4_valid", 64'(mem_v), 64'(1));
      check_eq("t4_addr", mem_a, 64'hABC0);
      check_eq("t4_src", 64'(mem_src), 64'(0));
      check_eq("t4_no_ready", 64'(dmd_rdy), 64'(0));
    end
    mem_rdy = 1; dmd_v = 0;
    step();

    // Flush and replace in one cycle.
    do_reset();
    limit = 6'd0;
    pf_v = 2'b10; pf_a[2*AW-1:AW] = 64'h2000;
    step();
    pf_fl = 2'b10; pf_a[2*AW-1:AW] = 64'h2040;
    step();
    check_eq("t5_no_drop", 64'(dropped[1]), 64'(0));
    pf_v = '0; pf_fl = '0; limit = 6'd8;
    seen_new = 0; seen_old = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (mem_v && mem_src == 2'd2 && mem_a == 64'h2040) seen_new = 1;
      if (mem_v && mem_src == 2'd2 && mem_a == 64'h2000) seen_old = 1;
    end
    check_eq("t5_new_issued", 64'(seen_new), 64'(1));
    check_eq("t5_old_never", 64'(seen_old), 64'(0));

    // Random traffic, including occasional mid-run reset.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      reset   = ($urandom_range(0, 63) == 0);
      dmd_v   = 1'($urandom);
      dmd_a   = {$urandom, $urandom};
      pf_v    = 2'($urandom);
      pf_a    = {$urandom, $urandom, $urandom, $urandom};
      pf_fl   = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      mem_rdy = ($urandom_range(0, 3) != 0);
      if (n % 50 == 0) limit = 6'($urandom_range(0, 3));
      rsp_src = 2'($urandom_range(0, 3));
      rsp_v   = 1'($urandom);
      if (rsp_src inside {2'd1, 2'd2} && m_cnt[int'(rsp_src) - 1] == 0) rsp_v = 0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
